// File: rtl/acc_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : acc_sequencer
// Purpose  : Fetch/decode/execute sequencer that owns the accumulator and
//            drives the downstream ALU operand/opcode inputs.
// Revision : 1.0 - initial release
// ============================================================================
module acc_sequencer #(
  parameter int unsigned ADDR_W   = 8,
  parameter int unsigned ALU_LAT  = 1,
  parameter int unsigned RESET_PC = 0
) (
  input  logic              execlk,
  input  logic              reset,
  input  logic              start,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [31:0]       imem_rdata,
  input  logic              imem_valid,
  output logic [31:0]       alu_acc,
  output logic [31:0]       alu_data,
  output logic [3:0]        alu_opcode,
  input  logic [31:0]       alu_result,
  output logic [31:0]       acc_out,
  output logic [ADDR_W-1:0] pc_out,
  output logic              busy,
  output logic              halted
);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_EXEC   = 3'd3,
    ST_WB     = 3'd4,
    ST_HALT   = 3'd5
  } state_t;

  localparam int unsigned       c_lat_w    = (ALU_LAT > 1) ? $clog2(ALU_LAT + 1) : 1;
  localparam logic [ADDR_W-1:0] c_reset_pc = ADDR_W'(RESET_PC);
  localparam logic [ADDR_W-1:0] c_pc_one   = ADDR_W'(1);
  localparam logic [c_lat_w-1:0] c_lat_ld  = c_lat_w'(ALU_LAT);
  localparam logic [c_lat_w-1:0] c_lat_one = c_lat_w'(1);

  state_t              r_state;
  logic [ADDR_W-1:0]   r_pc;
  logic [31:0]         r_acc;
  logic [31:0]         r_ir;
  logic                r_req;
  logic                r_busy;
  logic                r_halted;
  logic [31:0]         r_alu_acc;
  logic [31:0]         r_alu_data;
  logic [3:0]          r_alu_op;
  logic [c_lat_w-1:0]  r_lat_cnt;

  logic [1:0]          w_class;
  logic [31:0]         w_imm;

  assign w_class    = r_ir[27:26];
  assign w_imm      = {6'd0, r_ir[25:0]};

  assign imem_req   = r_req;
  assign imem_addr  = r_pc;
  assign pc_out     = r_pc;
  assign acc_out    = r_acc;
  assign alu_acc    = r_alu_acc;
  assign alu_data   = r_alu_data;
  assign alu_opcode = r_alu_op;
  assign busy       = r_busy;
  assign halted     = r_halted;

  always_ff @(posedge execlk or posedge reset) begin
    if (reset) begin
      r_state    <= ST_IDLE;
      r_pc       <= c_reset_pc;
      r_acc      <= '0;
      r_ir       <= '0;
      r_req      <= 1'b0;
      r_busy     <= 1'b0;
      r_halted   <= 1'b0;
      r_alu_acc  <= '0;
      r_alu_data <= '0;
      r_alu_op   <= '0;
      r_lat_cnt  <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_state <= ST_FETCH;
            r_req   <= 1'b1;
            r_busy  <= 1'b1;
          end
        end
        ST_FETCH: begin
          if (imem_valid && r_req) begin
            r_ir    <= imem_rdata;
            r_req   <= 1'b0;
            r_state <= ST_DECODE;
          end
        end
        ST_DECODE: begin
          case (w_class)
            2'b00: begin
              // ALU inputs are only ever written here, so they stay stable through EXEC.
              r_alu_acc  <= r_acc;
              r_alu_data <= w_imm;
              r_alu_op   <= r_ir[31:28];
              r_lat_cnt  <= c_lat_ld;
              r_state    <= ST_EXEC;
            end
            2'b01: begin
              r_acc   <= w_imm;
              r_pc    <= r_pc + c_pc_one;
              r_req   <= 1'b1;
              r_state <= ST_FETCH;
            end
            2'b10: begin
              r_pc    <= r_pc + c_pc_one;
              r_req   <= 1'b1;
              r_state <= ST_FETCH;
            end
            default: begin
              r_busy   <= 1'b0;
              r_halted <= 1'b1;
              r_state  <= ST_HALT;
            end
          endcase
        end
        ST_EXEC: begin
          r_lat_cnt <= r_lat_cnt - c_lat_one;
          if (r_lat_cnt == c_lat_one) begin
            r_state <= ST_WB;
          end
        end
        ST_WB: begin
          r_acc   <= alu_result;
          r_pc    <= r_pc + c_pc_one;
          r_req   <= 1'b1;
          r_state <= ST_FETCH;
        end
        ST_HALT: begin
          r_state <= ST_HALT;
        end
        default: begin
          r_state <= ST_IDLE;
          r_req   <= 1'b0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_acc_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_acc_sequencer
// Purpose  : Self-checking bench for acc_sequencer with an instruction-level
//            reference interpreter, a latency-aware ALU model and memory stalls.
// Revision : 1.0 - initial release
// ============================================================================
module tb_acc_sequencer;

  logic execlk = 1'b0;
  logic reset  = 1'b1;
  always #5 execlk = ~execlk;

  logic [2:0]  start = '0;
  logic [2:0]  imem_req, busy, halted;
  logic        imem_valid [3];
  logic [31:0] imem_rdata [3];
  logic [31:0] alu_result [3];
  logic [31:0] alu_acc [3], alu_data [3], acc_out [3];
  logic [3:0]  alu_opcode [3];
  logic [7:0]  imem_addr [3], pc_out [3];

  logic [31:0] mem [3][256];
  int stall_at [3], stall_len [3], stall_total [3], fetch_n [3];
  bit rnd_stall [3];
  int checks = 0;
  int errors = 0;

  // Instance 0: ADDR_W=8, ALU_LAT=1; instance 1: ALU_LAT=3; instance 2: ADDR_W=2, RESET_PC=3.
  function automatic int aw_of(int g);  return (g == 2) ? 2 : 8; endfunction
  function automatic int lat_of(int g); return (g == 1) ? 3 : 1; endfunction
  function automatic int rpc_of(int g); return (g == 2) ? 3 : 0; endfunction

  function automatic logic [31:0] alu_fn(logic [31:0] a, logic [31:0] b, logic [3:0] op);
    if (op == 4'd0) return a + b;
    if (op == 4'd1) return a - b;
    return a ^ b;
  endfunction

  function automatic logic [31:0] ins(logic [3:0] op, logic [1:0] cls, logic [25:0] imm);
    return {op, cls, imm};
  endfunction

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int AW  = (g == 2) ? 2 : 8;
    localparam int LAT = (g == 1) ? 3 : 1;
    localparam int RPC = (g == 2) ? 3 : 0;
    logic [AW-1:0] w_addr, w_pc;

    acc_sequencer #(.ADDR_W(AW), .ALU_LAT(LAT), .RESET_PC(RPC)) u_dut (
      .execlk    (execlk),
      .reset     (reset),
      .start     (start[g]),
      .imem_req  (imem_req[g]),
      .imem_addr (w_addr),
      .imem_rdata(imem_rdata[g]),
      .imem_valid(imem_valid[g]),
      .alu_acc   (alu_acc[g]),
      .alu_data  (alu_data[g]),
      .alu_opcode(alu_opcode[g]),
      .alu_result(alu_result[g]),
      .acc_out   (acc_out[g]),
      .pc_out    (w_pc),
      .busy      (busy[g]),
      .halted    (halted[g])
    );
    assign imem_addr[g] = 8'(w_addr);
    assign pc_out[g]    = 8'(w_pc);

    // Memory: per-fetch stall, random junk valids while no request is pending.
    initial begin : responder
      int cnt, cur;
      bit inf;
      imem_valid[g] = 1'b0; imem_rdata[g] = '0; inf = 0; cnt = 0; cur = 0;
      forever begin
        @(posedge execlk); #1;
        if (imem_req[g]) begin
          if (!inf) begin
            inf = 1; cnt = 0;
            cur = (fetch_n[g] == stall_at[g]) ? stall_len[g] :
                  (rnd_stall[g] ? int'($urandom_range(0, 2)) : 0);
          end
          if (cnt >= cur) begin
            imem_valid[g] = 1'b1; imem_rdata[g] = mem[g][imem_addr[g]];
            fetch_n[g]++; inf = 0;
          end else begin
            imem_valid[g] = 1'b0; cnt++; stall_total[g]++;
          end
        end else begin
          inf = 0;
          imem_valid[g] = 1'($urandom_range(0, 1));
          imem_rdata[g] = $urandom;
        end
      end
    end

    // ALU: result is garbage until inputs have been stable for more than LAT cycles.
    initial begin : alu_model
      logic [31:0] la, ld;
      logic [3:0]  lo;
      int scnt;
      la = '0; ld = '0; lo = '0; scnt = 0; alu_result[g] = '0;
      forever begin
        @(posedge execlk); #1;
        if (alu_acc[g] !== la || alu_data[g] !== ld || alu_opcode[g] !== lo) begin
          la = alu_acc[g]; ld = alu_data[g]; lo = alu_opcode[g]; scnt = 1;
        end else begin
          scnt++;
        end
        alu_result[g] = (scnt > LAT) ? alu_fn(la, ld, lo) : 32'hDEAD_BEEF;
      end
    end
  end

  task automatic do_reset();
    reset = 1'b1; start = '0;
    for (int g = 0; g < 3; g++) begin
      stall_at[g] = -1; stall_len[g] = 0; stall_total[g] = 0; fetch_n[g] = 0; rnd_stall[g] = 0;
      for (int a = 0; a < 256; a++) mem[g][a] = ins(4'd0, 2'b11, 26'd0);
    end
    repeat (2) @(posedge execlk);
    #3 reset = 1'b0;
    @(posedge execlk); #1;
  endtask

  task automatic pulse_start(int g);
    @(posedge execlk); #1 start[g] = 1'b1;
    @(posedge execlk); #1 start[g] = 1'b0;
  endtask

  task automatic wait_halt(int g, output int n, output bit to);
    n = 0; to = 0;
    while (!halted[g]) begin
      if (n >= 3000) begin to = 1; break; end
      @(posedge execlk); #1; n++;
    end
  endtask

  // Instruction-level interpreter: final accumulator, PC and zero-stall cycle count.
  task automatic model(int g, output logic [31:0] macc, output int mpc, output int mcyc);
    int pc;
    logic [31:0] w;
    pc = rpc_of(g); macc = '0; mcyc = 0;
    for (int s = 0; s < 2000; s++) begin
      w = mem[g][pc];
      if (w[27:26] == 2'b11) begin mcyc += 2; break; end
      if (w[27:26] == 2'b00) begin
        macc = alu_fn(macc, {6'd0, w[25:0]}, w[31:28]); mcyc += 3 + lat_of(g);
      end else begin
        if (w[27:26] == 2'b01) macc = {6'd0, w[25:0]};
        mcyc += 2;
      end
      pc = (pc + 1) % (1 << aw_of(g));
    end
    mpc = pc;
  endtask

  task automatic load_add_prog(int g);
    mem[g][0] = ins(4'd0, 2'b01, 26'd1);
    mem[g][1] = ins(4'd0, 2'b00, 26'd1);
    mem[g][2] = ins(4'd0, 2'b11, 26'd0);
  endtask

  task automatic test_reset();
    do_reset();
    for (int g = 0; g < 3; g++) begin
      checks++;
      if ({imem_req[g], busy[g], halted[g]} !== 3'b000) begin
        errors++; $display("FAIL reset_ctrl[%0d]: req/busy/halted got %b want 000", g, {imem_req[g], busy[g], halted[g]});
      end
      checks++;
      if (pc_out[g] !== 8'(rpc_of(g))) begin
        errors++; $display("FAIL reset_pc[%0d]: got %0d want %0d", g, pc_out[g], rpc_of(g));
      end
      checks++;
      if (acc_out[g] !== 32'd0 || alu_acc[g] !== 32'd0 || alu_data[g] !== 32'd0 || alu_opcode[g] !== 4'd0) begin
        errors++; $display("FAIL reset_data[%0d]: acc %h alu %h/%h/%h want all zero", g, acc_out[g], alu_acc[g], alu_data[g], alu_opcode[g]);
      end
    end
  endtask

  task automatic test_add();
    int n; bit to;
    do_reset(); load_add_prog(0);
    pulse_start(0); wait_halt(0, n, to);
    checks++; if (to) begin errors++; $display("FAIL add_timeout: got timeout want halt"); end
    checks++; if (acc_out[0] !== 32'd2) begin errors++; $display("FAIL add_acc: got %h want 00000002", acc_out[0]); end
    checks++; if (pc_out[0] !== 8'd2) begin errors++; $display("FAIL add_pc: got %0d want 2", pc_out[0]); end
    checks++; if (busy[0] !== 1'b0 || halted[0] !== 1'b1) begin errors++; $display("FAIL add_flags: busy %b halted %b want 0 1", busy[0], halted[0]); end
    checks++; if (n !== 8) begin errors++; $display("FAIL add_cycles: got %0d want 8", n); end
  endtask

  task automatic test_sub();
    int n, ex, bad;
    do_reset();
    mem[0][0] = ins(4'd0, 2'b01, 26'd3);
    mem[0][1] = ins(4'd1, 2'b00, 26'd1);
    pulse_start(0);
    n = 0; ex = 0; bad = 0;
    while (!halted[0] && n < 200) begin
      @(posedge execlk); #1; n++;
      if (alu_opcode[0] == 4'd1) begin
        ex++;
        if (alu_acc[0] !== 32'd3 || alu_data[0] !== 32'd1) bad++;
      end
    end
    checks++; if (acc_out[0] !== 32'd2) begin errors++; $display("FAIL sub_acc: got %h want 00000002", acc_out[0]); end
    checks++; if (bad !== 0) begin errors++; $display("FAIL sub_alu_stable: got %0d unstable cycles want 0", bad); end
    checks++; if (ex !== 5) begin errors++; $display("FAIL sub_alu_hold: got %0d cycles want 5", ex); end
  endtask

  task automatic test_stall();
    int n, hold;
    do_reset(); load_add_prog(0);
    stall_at[0] = 1; stall_len[0] = 5;
    pulse_start(0);
    n = 0; hold = 0;
    while (!halted[0] && n < 200) begin
      @(posedge execlk); #1; n++;
      if (imem_req[0] && imem_addr[0] == 8'd1) hold++;
    end
    checks++; if (hold !== 6) begin errors++; $display("FAIL stall_req_hold: got %0d cycles want 6", hold); end
    checks++; if (n !== 13) begin errors++; $display("FAIL stall_cycles: got %0d want 13", n); end
    checks++; if (acc_out[0] !== 32'd2 || pc_out[0] !== 8'd2) begin errors++; $display("FAIL stall_result: acc %h pc %0d want 2 2", acc_out[0], pc_out[0]); end
  endtask

  task automatic test_wrap();
    int seq[$];
    int n;
    logic prev;
    do_reset();
    mem[2][3] = ins(4'd0, 2'b10, 26'd0);
    mem[2][0] = ins(4'd0, 2'b01, 26'd7);
    mem[2][1] = ins(4'd0, 2'b11, 26'd0);
    pulse_start(2);
    seq.push_back(int'(imem_addr[2]));
    prev = 1'b1; n = 0;
    while (!halted[2] && n < 200) begin
      @(posedge execlk); #1; n++;
      if (imem_req[2] && !prev) seq.push_back(int'(imem_addr[2]));
      prev = imem_req[2];
    end
    checks++;
    if (seq.size() != 3 || seq[0] != 3 || seq[1] != 0 || seq[2] != 1) begin
      errors++; $display("FAIL wrap_pc_seq: got %p want '{3, 0, 1}", seq);
    end
    checks++; if (acc_out[2] !== 32'd7 || pc_out[2] !== 8'd1) begin errors++; $display("FAIL wrap_result: acc %h pc %0d want 7 1", acc_out[2], pc_out[2]); end
  endtask

  task automatic test_reset_mid_exec();
    int n;
    do_reset(); load_add_prog(1);
    pulse_start(1);
    n = 0;
    while (!(alu_acc[1] == 32'd1 && alu_data[1] == 32'd1) && n < 100) begin
      @(posedge execlk); #1; n++;
    end
    checks++; if (n >= 100) begin errors++; $display("FAIL rst_exec_reach: got timeout want EXEC"); end
    #2 reset = 1'b1;
    #1;
    checks++;
    if (acc_out[1] !== 32'd0 || busy[1] !== 1'b0 || imem_req[1] !== 1'b0 || pc_out[1] !== 8'd0 ||
        alu_acc[1] !== 32'd0 || alu_data[1] !== 32'd0 || alu_opcode[1] !== 4'd0 || halted[1] !== 1'b0) begin
      errors++; $display("FAIL rst_exec_async: acc %h busy %b req %b pc %0d alu %h/%h/%h want reset values",
                         acc_out[1], busy[1], imem_req[1], pc_out[1], alu_acc[1], alu_data[1], alu_opcode[1]);
    end
    @(posedge execlk); #3 reset = 1'b0;
    repeat (6) @(posedge execlk); #1;
    checks++; if (acc_out[1] !== 32'd0 || busy[1] !== 1'b0) begin errors++; $display("FAIL rst_exec_no_wb: acc %h busy %b want 0 0", acc_out[1], busy[1]); end
  endtask

  task automatic test_start_ignored();
    int n; bit to;
    do_reset(); load_add_prog(0);
    stall_at[0] = 0; stall_len[0] = 4;
    pulse_start(0);
    @(posedge execlk); #1 start[0] = 1'b1;
    @(posedge execlk); #1 start[0] = 1'b0;
    checks++; if (pc_out[0] !== 8'd0 || imem_req[0] !== 1'b1) begin errors++; $display("FAIL start_in_fetch: pc %0d req %b want 0 1", pc_out[0], imem_req[0]); end
    wait_halt(0, n, to);
    checks++; if (to || acc_out[0] !== 32'd2 || pc_out[0] !== 8'd2) begin errors++; $display("FAIL start_fetch_result: acc %h pc %0d to %b want 2 2 0", acc_out[0], pc_out[0], to); end
    @(posedge execlk); #1 start[0] = 1'b1;
    @(posedge execlk); #1 start[0] = 1'b0;
    repeat (3) @(posedge execlk); #1;
    checks++;
    if (halted[0] !== 1'b1 || busy[0] !== 1'b0 || imem_req[0] !== 1'b0 || pc_out[0] !== 8'd2 || acc_out[0] !== 32'd2) begin
      errors++; $display("FAIL start_in_halt: halted %b busy %b req %b pc %0d acc %h want 1 0 0 2 2", halted[0], busy[0], imem_req[0], pc_out[0], acc_out[0]);
    end
  endtask

  task automatic test_lat3();
    int n, t_ex, t_wb;
    do_reset(); load_add_prog(1);
    pulse_start(1);
    n = 0; t_ex = -1; t_wb = -1;
    while (!halted[1] && n < 200) begin
      @(posedge execlk); #1; n++;
      if (t_ex < 0 && alu_acc[1] == 32'd1 && alu_data[1] == 32'd1) t_ex = n;
      if (t_wb < 0 && acc_out[1] == 32'd2) t_wb = n;
    end
    checks++; if (t_wb - t_ex !== 4) begin errors++; $display("FAIL lat3_wb_timing: got %0d want 4", t_wb - t_ex); end
    checks++; if (n !== 10) begin errors++; $display("FAIL lat3_cycles: got %0d want 10", n); end
    checks++; if (acc_out[1] !== 32'd2) begin errors++; $display("FAIL lat3_acc: got %h want 00000002", acc_out[1]); end
  endtask

  task automatic test_random();
    int n, len, mpc, mcyc; bit to;
    logic [31:0] macc;
    logic [25:0] imm;
    for (int g = 0; g < 2; g++) begin
      for (int it = 0; it < 4; it++) begin
        do_reset();
        len = int'($urandom_range(3, 25));
        for (int a = 0; a < len; a++) begin
          imm = ($urandom_range(0, 3) == 0) ? 26'h3FF_FFFF : 26'($urandom);
          mem[g][a] = ins(4'($urandom), 2'($urandom_range(0, 2)), imm);
        end
        rnd_stall[g] = 1;
        model(g, macc, mpc, mcyc);
        pulse_start(g); wait_halt(g, n, to);
        checks++; if (to || acc_out[g] !== macc) begin errors++; $display("FAIL rand_acc[%0d.%0d]: got %h want %h", g, it, acc_out[g], macc); end
        checks++; if (pc_out[g] !== 8'(mpc)) begin errors++; $display("FAIL rand_pc[%0d.%0d]: got %0d want %0d", g, it, pc_out[g], mpc); end
        checks++; if (n !== mcyc + stall_total[g]) begin errors++; $display("FAIL rand_cycles[%0d.%0d]: got %0d want %0d", g, it, n, mcyc + stall_total[g]); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_sub();
    test_stall();
    test_wrap();
    test_reset_mid_exec();
    test_start_ignored();
    test_lat3();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
